// File: rtl/skew_buffer_pkg.sv
// rtl/skew_buffer_pkg.sv - shared defines, lane depth helpers for skew_buffer
// Optional feature macro SKEW_BUF_LAST_EN stays undefined by default (no last/done tracking)
`ifndef WIDTH_DATA
`define WIDTH_DATA 8
`endif

package skew_buffer_pkg;

  localparam int DEFAULT_WIDTH = `WIDTH_DATA;

  // Lane k: BASE_DELAY+k cycles when skewing, mirrored when deskewing.
  function automatic int lane_depth(input int base_delay, input int channels,
                                    input bit reverse, input int k);
    return reverse ? (base_delay + channels - 1 - k) : (base_delay + k);
  endfunction

  function automatic int longest_lane(input int channels, input bit reverse);
    return reverse ? 0 : (channels - 1);
  endfunction

endpackage

// File: rtl/skew_lane.sv
// rtl/skew_lane.sv - one lane of the skew buffer: DEPTH-stage {valid,tag,data} shift chain
// Tag register exists only when TAG_W>0; invalid slots always carry zero data.
module skew_lane
  import skew_buffer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = 1,
  parameter int TAG_W = 0
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  clear,
  input  logic                                  en,
  input  logic                                  din_valid,
  input  logic [WIDTH-1:0]                      din,
  input  logic [((TAG_W > 0) ? TAG_W : 1)-1:0]  din_tag,
  output logic                                  dout_valid,
  output logic [WIDTH-1:0]                      dout,
  output logic [((TAG_W > 0) ? TAG_W : 1)-1:0]  dout_tag
);

  logic             valid_q [DEPTH];
  logic [WIDTH-1:0] data_q  [DEPTH];

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      for (int j = 0; j < DEPTH; j++) begin
        valid_q[j] <= 1'b0;
        data_q[j]  <= '0;
      end
    end else if (en) begin
      valid_q[0] <= din_valid;
      data_q[0]  <= din_valid ? din : '0;
      for (int j = 1; j < DEPTH; j++) begin
        valid_q[j] <= valid_q[j-1];
        data_q[j]  <= data_q[j-1];
      end
    end
  end

  assign dout_valid = valid_q[DEPTH-1];
  assign dout       = data_q[DEPTH-1];

  generate
    if (TAG_W > 0) begin : g_tag
      logic [TAG_W-1:0] tag_q [DEPTH];

      always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
          for (int j = 0; j < DEPTH; j++) tag_q[j] <= '0;
        end else if (en) begin
          tag_q[0] <= din_valid ? din_tag : '0;
          for (int j = 1; j < DEPTH; j++) tag_q[j] <= tag_q[j-1];
        end
      end

      assign dout_tag = tag_q[DEPTH-1];
    end else begin : g_no_tag
      logic unused_tag;
      assign unused_tag = ^din_tag;
      assign dout_tag   = '0;
    end
  endgenerate

endmodule

// File: rtl/skew_buffer.sv
// rtl/skew_buffer.sv - multi-lane skew/deskew delay line feeding the systolic array edges
// Define SKEW_BUF_LAST_EN to add din_last/done tile-end tracking on the longest lane.
module skew_buffer
  import skew_buffer_pkg::*;
#(
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter int CHANNELS   = 4,
  parameter int BASE_DELAY = 1,
  parameter int REVERSE    = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear,
  input  logic                       en,
  input  logic                       din_valid,
  input  logic [CHANNELS*WIDTH-1:0]  din,
`ifdef SKEW_BUF_LAST_EN
  input  logic                       din_last,
  output logic                       done,
`endif
  output logic [CHANNELS-1:0]        dout_valid,
  output logic [CHANNELS*WIDTH-1:0]  dout
);

  localparam int LONG = longest_lane(CHANNELS, REVERSE != 0);

  generate
    if (CHANNELS < 1 || BASE_DELAY < 1) begin : g_bad_params
      $error("skew_buffer: CHANNELS and BASE_DELAY must both be >= 1");
    end
  endgenerate

`ifdef SKEW_BUF_LAST_EN
  localparam int LONG_TAG_W = 1;
  logic last_in;
  assign last_in = din_last;
`else
  localparam int LONG_TAG_W = 0;
  logic last_in;
  assign last_in = 1'b0;
`endif

  logic [CHANNELS-1:0] tag_out;

  generate
    for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
      localparam int DEPTH = lane_depth(BASE_DELAY, CHANNELS, REVERSE != 0, k);
      localparam int TAG_W = (k == LONG) ? LONG_TAG_W : 0;

      skew_lane #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .TAG_W (TAG_W)
      ) u_lane (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .en         (en),
        .din_valid  (din_valid),
        .din        (din[k*WIDTH +: WIDTH]),
        .din_tag    (last_in),
        .dout_valid (dout_valid[k]),
        .dout       (dout[k*WIDTH +: WIDTH]),
        .dout_tag   (tag_out[k])
      );
    end
  endgenerate

  // Only the longest lane carries a real tag; the rest are tied-off zeros.
  logic unused_tags;
  assign unused_tags = ^tag_out;

`ifdef SKEW_BUF_LAST_EN
  assign done = dout_valid[LONG] & tag_out[LONG];
`endif

endmodule

// File: tb/tb_skew_buffer.sv
// tb/tb_skew_buffer.sv - self-checking bench for skew_buffer (forward and reverse instances)
// Reference model: history of accepted vectors, lane k shows the entry D_k en-edges back.
module tb_skew_buffer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic        en = 1'b0;
  logic        din_valid = 1'b0;
  logic        din_last = 1'b0;
  logic [31:0] din = '0;
  logic [3:0]  dv_f, dv_r;
  logic [31:0] do_f, do_r;
`ifdef SKEW_BUF_LAST_EN
  logic        done_f, done_r;
`endif

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic        v;
    logic        l;
    logic [31:0] d;
  } slot_t;

  slot_t       hist[$];
  logic [3:0]  exp_dv_f, exp_dv_r;
  logic [31:0] exp_do_f, exp_do_r;
  logic        exp_done;

  always #5 clk = ~clk;

  skew_buffer #(.WIDTH(8), .CHANNELS(4), .BASE_DELAY(1), .REVERSE(0)) u_fwd (
    .clk(clk), .rst_n(rst_n), .clear(clear), .en(en), .din_valid(din_valid), .din(din),
`ifdef SKEW_BUF_LAST_EN
    .din_last(din_last), .done(done_f),
`endif
    .dout_valid(dv_f), .dout(do_f)
  );

  skew_buffer #(.WIDTH(8), .CHANNELS(4), .BASE_DELAY(1), .REVERSE(1)) u_rev (
    .clk(clk), .rst_n(rst_n), .clear(clear), .en(en), .din_valid(din_valid), .din(din),
`ifdef SKEW_BUF_LAST_EN
    .din_last(din_last), .done(done_r),
`endif
    .dout_valid(dv_r), .dout(do_r)
  );

  task automatic model_edge();
    slot_t s;
    int    df, dr;
    if (!rst_n || clear) begin
      hist.delete();
    end else if (en) begin
      s.v = din_valid;
      s.l = din_valid & din_last;
      s.d = din_valid ? din : 32'h0;
      hist.push_back(s);
      if (hist.size() > 8) void'(hist.pop_front());
    end
    exp_dv_f = '0; exp_do_f = '0; exp_dv_r = '0; exp_do_r = '0; exp_done = 1'b0;
    for (int k = 0; k < 4; k++) begin
      df = 1 + k;
      dr = 4 - k;
      if (hist.size() >= df) begin
        s = hist[hist.size() - df];
        exp_dv_f[k] = s.v;
        exp_do_f[k*8 +: 8] = s.d[k*8 +: 8];
      end
      if (hist.size() >= dr) begin
        s = hist[hist.size() - dr];
        exp_dv_r[k] = s.v;
        exp_do_r[k*8 +: 8] = s.d[k*8 +: 8];
      end
    end
    if (hist.size() >= 4) begin
      s = hist[hist.size() - 4];
      exp_done = s.v & s.l;
    end
  endtask

  task automatic tick(input logic c, input logic e, input logic v, input logic [31:0] d,
                      input logic l);
    clear = c; en = e; din_valid = v; din = d; din_last = l;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b1);
      n_checks++;
      if ({dv_f, do_f, dv_r, do_r} !== 72'h0) begin
        n_errors++;
        $display("FAIL reset cyc%0d: got f=%h/%h r=%h/%h, want all zero", i, dv_f, do_f, dv_r, do_r);
      end
`ifdef SKEW_BUF_LAST_EN
      n_checks++;
      if ({done_f, done_r} !== 2'b00) begin
        n_errors++;
        $display("FAIL reset_done cyc%0d: got %b%b want 00", i, done_f, done_r);
      end
`endif
    end
    rst_n = 1'b1;
  endtask

  task automatic test_skew();
    logic [3:0]  wv_f, wv_r;
    logic [31:0] wd_f, wd_r;
    tick(1'b0, 1'b1, 1'b1, 32'h0403_0201, 1'b0);
    for (int n = 1; n <= 6; n++) begin
      wv_f = '0; wd_f = '0; wv_r = '0; wd_r = '0;
      if (n <= 4) begin
        wv_f[n-1] = 1'b1;
        wd_f[(n-1)*8 +: 8] = 8'(n);
        wv_r[4-n] = 1'b1;
        wd_r[(4-n)*8 +: 8] = 8'(5 - n);
      end
      n_checks++;
      if ({dv_f, do_f, dv_r, do_r} !== {wv_f, wd_f, wv_r, wd_r}) begin
        n_errors++;
        $display("FAIL skew t0+%0d: got f=%h/%h r=%h/%h want f=%h/%h r=%h/%h",
                 n, dv_f, do_f, dv_r, do_r, wv_f, wd_f, wv_r, wd_r);
      end
      tick(1'b0, 1'b1, 1'b0, 32'($urandom), 1'b0);
    end
  endtask

  task automatic test_stall();
    int          seen [4];
    logic [31:0] vec;
    vec = 32'($urandom);
    for (int k = 0; k < 4; k++) seen[k] = 0;
    tick(1'b0, 1'b1, 1'b1, vec, 1'b0);
    for (int i = 1; i <= 9; i++) begin
      n_checks++;
      if ({dv_f, do_f, dv_r, do_r} !== {exp_dv_f, exp_do_f, exp_dv_r, exp_do_r}) begin
        n_errors++;
        $display("FAIL stall t0+%0d: got f=%h/%h r=%h/%h want f=%h/%h r=%h/%h",
                 i, dv_f, do_f, dv_r, do_r, exp_dv_f, exp_do_f, exp_dv_r, exp_do_r);
      end
      for (int k = 0; k < 4; k++) if (dv_f[k] === 1'b1 && i != 2 && i != 3 && i != 4) seen[k]++;
      if (i == 6 || i == 7) begin
        n_checks++;
        if (dv_f !== (i == 6 ? 4'b0100 : 4'b1000)) begin
          n_errors++;
          $display("FAIL stall_arrival t0+%0d: got %b want %b", i, dv_f, (i == 6 ? 4'b0100 : 4'b1000));
        end
      end
      tick(1'b0, !(i >= 2 && i <= 4), 1'b0, 32'($urandom), 1'b0);
    end
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (seen[k] != 1) begin
        n_errors++;
        $display("FAIL stall_count lane%0d: got %0d want 1", k, seen[k]);
      end
    end
  endtask

  task automatic test_clear();
    logic [31:0] vd;
    int          total;
    total = 0;
    vd = 32'($urandom) | 32'h1;
    tick(1'b0, 1'b1, 1'b1, 32'($urandom), 1'b0);
    tick(1'b0, 1'b1, 1'b1, 32'($urandom), 1'b0);
    tick(1'b1, 1'b1, 1'b1, 32'($urandom), 1'b0);
    n_checks++;
    if ({dv_f, do_f, dv_r, do_r} !== 72'h0) begin
      n_errors++;
      $display("FAIL clear_flush: got f=%h/%h r=%h/%h want all zero", dv_f, do_f, dv_r, do_r);
    end
    tick(1'b0, 1'b1, 1'b1, vd, 1'b0);
    n_checks++;
    if (dv_f[0] !== 1'b1 || do_f[7:0] !== vd[7:0]) begin
      n_errors++;
      $display("FAIL clear_next: got %b/%h want 1/%h", dv_f[0], do_f[7:0], vd[7:0]);
    end
    for (int i = 0; i < 6; i++) begin
      for (int k = 0; k < 4; k++) if (dv_f[k] === 1'b1) total++;
      n_checks++;
      if ({dv_f, do_f, dv_r, do_r} !== {exp_dv_f, exp_do_f, exp_dv_r, exp_do_r}) begin
        n_errors++;
        $display("FAIL clear cyc%0d: got f=%h/%h r=%h/%h want f=%h/%h r=%h/%h",
                 i, dv_f, do_f, dv_r, do_r, exp_dv_f, exp_do_f, exp_dv_r, exp_do_r);
      end
      tick(1'b0, 1'b1, 1'b0, 32'($urandom), 1'b0);
    end
    n_checks++;
    if (total != 4) begin
      n_errors++;
      $display("FAIL clear_count: got %0d valid lane words want 4", total);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 12; i++) begin
      tick(1'b0, 1'b1, 1'b1, 32'($urandom), 1'b0);
      n_checks++;
      if ({dv_f, do_f, dv_r, do_r} !== {exp_dv_f, exp_do_f, exp_dv_r, exp_do_r}) begin
        n_errors++;
        $display("FAIL b2b cyc%0d: got f=%h/%h r=%h/%h want f=%h/%h r=%h/%h",
                 i, dv_f, do_f, dv_r, do_r, exp_dv_f, exp_do_f, exp_dv_r, exp_do_r);
      end
      if (i >= 3) begin
        n_checks++;
        if ({dv_f, dv_r} !== 8'hFF) begin
          n_errors++;
          $display("FAIL b2b_full cyc%0d: got %h/%h want f/f", i, dv_f, dv_r);
        end
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      tick($urandom_range(0, 24) == 0, $urandom_range(0, 3) != 0, 1'($urandom),
           32'($urandom), $urandom_range(0, 3) == 0);
      n_checks++;
      if ({dv_f, do_f, dv_r, do_r} !== {exp_dv_f, exp_do_f, exp_dv_r, exp_do_r}) begin
        n_errors++;
        $display("FAIL random cyc%0d: got f=%h/%h r=%h/%h want f=%h/%h r=%h/%h",
                 i, dv_f, do_f, dv_r, do_r, exp_dv_f, exp_do_f, exp_dv_r, exp_do_r);
      end
`ifdef SKEW_BUF_LAST_EN
      n_checks++;
      if ({done_f, done_r} !== {exp_done, exp_done}) begin
        n_errors++;
        $display("FAIL random_done cyc%0d: got %b%b want %b%b", i, done_f, done_r, exp_done, exp_done);
      end
`endif
    end
  endtask

`ifdef SKEW_BUF_LAST_EN
  task automatic test_last(input bit stall);
    logic [31:0] fifth;
    int          want_at;
    fifth = 32'($urandom);
    want_at = stall ? 10 : 8;
    tick(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 13; i++) begin
      tick(1'b0, !(stall && (i == 5 || i == 6)), i < 5, (i == 4) ? fifth : 32'($urandom), i == 4);
      n_checks++;
      if ({done_f, done_r} !== {2{(i + 1) == want_at}}) begin
        n_errors++;
        $display("FAIL last stall=%0d t0+%0d: got %b%b want %b", stall, i + 1, done_f, done_r,
                 (i + 1) == want_at);
      end
      if ((i + 1) == want_at) begin
        n_checks++;
        if (do_f[31:24] !== fifth[31:24] || do_r[7:0] !== fifth[7:0]) begin
          n_errors++;
          $display("FAIL last_word: got %h/%h want %h/%h", do_f[31:24], do_r[7:0],
                   fifth[31:24], fifth[7:0]);
        end
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_skew();
    test_stall();
    test_clear();
    test_back_to_back();
`ifdef SKEW_BUF_LAST_EN
    test_last(1'b0);
    test_last(1'b1);
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
